// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - JK flip-flop bank excitation driver with check/retry (optional macro JK_TOGGLE_EN)
module jk_excite_driver #(
    parameter int WIDTH     = 4,
    parameter int RETRY_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       retries
);

    localparam int CW = (RETRY_MAX > 3) ? $clog2(RETRY_MAX + 1) : 2;
    localparam logic [CW-1:0] RMAX = CW'(RETRY_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [CW-1:0]    retry_cnt;

`ifdef JK_TOGGLE_EN
    // Toggle encoding: every changing bit gets J=K=1.
    function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] tgt);
        return cur ^ tgt;
    endfunction

    function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] tgt);
        return cur ^ tgt;
    endfunction
`else
    // Set/reset encoding: J sets rising bits, K clears falling bits, never both.
    function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] tgt);
        return ~cur & tgt;
    endfunction

    function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] tgt);
        return cur & ~tgt;
    endfunction
`endif

    // Request FSM: drive one cycle, check one cycle, retry or finish; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            target    <= '0;
            retry_cnt <= '0;
            j         <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            retries   <= 2'd0;
            tgt_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid && tgt_ready) begin
                        target    <= tgt_data;
                        retry_cnt <= '0;
                        err       <= 1'b0;
                        j         <= excite_j(q_fb, tgt_data);
                        k         <= excite_k(q_fb, tgt_data);
                        busy      <= 1'b1;
                        tgt_ready <= 1'b0;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    j     <= '0;
                    k     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_fb == target) begin
                        done    <= 1'b1;
                        retries <= retry_cnt[1:0];
                        state   <= FIN;
                    end else if (retry_cnt < RMAX) begin
                        retry_cnt <= retry_cnt + CW'(1);
                        j         <= excite_j(q_fb, target);
                        k         <= excite_k(q_fb, target);
                        state     <= DRIVE;
                    end else begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        retries <= retry_cnt[1:0];
                        state   <= FIN;
                    end
                end
                FIN: begin
                    busy      <= 1'b0;
                    tgt_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
